// File: rtl/psum_accum_ctrl_pkg.sv
// Shared types and arithmetic helpers for the psum read-modify-write controller.
// Optional build macro PSUM_SAT_EN selects saturating adds; see psum_adder.
package psum_pkg;

    localparam int PSUM_DW        = 16;
    localparam int PSUM_MEM_DEPTH = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic signed [PSUM_DW-1:0] SAT_MAX = {1'b0, {(PSUM_DW-1){1'b1}}};
    localparam logic signed [PSUM_DW-1:0] SAT_MIN = {1'b1, {(PSUM_DW-1){1'b0}}};

    // Saturating add for any operand width up to 32; operands arrive sign-extended.
    function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                   input logic signed [31:0] b,
                                                   input int width);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        s  = 64'(a) + 64'(b);
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (s > hi)
            s = hi;
        else if (s < lo)
            s = lo;
        return 32'(s);
    endfunction

endpackage

// File: rtl/psum_accum_ctrl_if.sv
// Product, psum-chain and scratchpad signals of the psum accumulation controller.
// master = the controller, slave = its surroundings (multiplier, neighbour PEs, spad).
interface psum_accum_ctrl_if
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DW,
    parameter int ADDR_WIDTH = $clog2(PSUM_MEM_DEPTH)
);
    logic                  prod_valid;
    logic                  prod_ready;
    logic [DATA_WIDTH-1:0] prod_data;
    logic [ADDR_WIDTH-1:0] prod_addr;
    logic                  prod_first;
    logic                  prod_last;

    logic                  psum_in_valid;
    logic                  psum_in_ready;
    logic [DATA_WIDTH-1:0] psum_in_data;

    logic                  psum_out_valid;
    logic                  psum_out_ready;
    logic [DATA_WIDTH-1:0] psum_out_data;

    logic                  spad_w_en;
    logic [DATA_WIDTH-1:0] spad_din;
    logic [ADDR_WIDTH-1:0] spad_w_addr;
    logic [ADDR_WIDTH-1:0] spad_r_addr;
    logic [DATA_WIDTH-1:0] spad_dout;

    modport master (
        input  prod_valid, prod_data, prod_addr, prod_first, prod_last,
        input  psum_in_valid, psum_in_data, psum_out_ready, spad_dout,
        output prod_ready, psum_in_ready, psum_out_valid, psum_out_data,
        output spad_w_en, spad_din, spad_w_addr, spad_r_addr
    );

    modport slave (
        output prod_valid, prod_data, prod_addr, prod_first, prod_last,
        output psum_in_valid, psum_in_data, psum_out_ready, spad_dout,
        input  prod_ready, psum_in_ready, psum_out_valid, psum_out_data,
        input  spad_w_en, spad_din, spad_w_addr, spad_r_addr
    );

endinterface

// File: rtl/psum_accum_ctrl_adder.sv
// Combinational signed psum adder: wraps by default, saturates when PSUM_SAT_EN is defined.
module psum_adder
    import psum_pkg::*;
#(
    parameter int DATA_WIDTH = PSUM_DW
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum
);

`ifdef PSUM_SAT_EN
    assign sum = DATA_WIDTH'(sat_add(32'(signed'(a)), 32'(signed'(b)), DATA_WIDTH));
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/psum_accum_ctrl.sv
// Psum spad read-modify-write controller: accumulate products, drain through the psum chain, pulse done.
// Build macro PSUM_SAT_EN switches both adders from wrapping to saturating arithmetic.
module psum_accum_ctrl
    import psum_pkg::*;
#(
    parameter int MEM_DEPTH  = PSUM_MEM_DEPTH,
    parameter int DATA_WIDTH = PSUM_DW,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
    parameter int CNT_WIDTH  = $clog2(MEM_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] num_psums,
    output logic                 busy,
    output logic                 done,
    psum_accum_ctrl_if.master    bus
);

    state_t                state_reg;
    logic [CNT_WIDTH-1:0]  num_psums_reg;
    logic [CNT_WIDTH-1:0]  drain_cnt_reg;
    logic                  out_valid_reg;
    logic [DATA_WIDTH-1:0] out_data_reg;

    logic                  num_ok;
    logic                  addr_ok;
    logic                  drain_left;
    logic                  prod_fire;
    logic                  in_ready;
    logic                  in_fire;
    logic [DATA_WIDTH-1:0] accum_old;
    logic [DATA_WIDTH-1:0] accum_sum;
    logic [DATA_WIDTH-1:0] drain_sum;

    assign num_ok     = (32'(num_psums) >= 1) && (32'(num_psums) <= MEM_DEPTH);
    assign addr_ok    = 32'(bus.prod_addr) < MEM_DEPTH;
    assign drain_left = drain_cnt_reg < num_psums_reg;
    assign prod_fire  = (state_reg == ACCUM) && bus.prod_valid;
    assign in_ready   = (state_reg == DRAIN) && drain_left && (!out_valid_reg || bus.psum_out_ready);
    assign in_fire    = in_ready && bus.psum_in_valid;

    // spad_dout is already valid mid-cycle, so the sum is ready before the write edge.
    assign accum_old = bus.prod_first ? '0 : bus.spad_dout;

    psum_adder #(.DATA_WIDTH(DATA_WIDTH)) u_accum_add (
        .a   (accum_old),
        .b   (bus.prod_data),
        .sum (accum_sum)
    );

    psum_adder #(.DATA_WIDTH(DATA_WIDTH)) u_drain_add (
        .a   (bus.spad_dout),
        .b   (bus.psum_in_data),
        .sum (drain_sum)
    );

    always_comb begin
        bus.prod_ready     = (state_reg == ACCUM);
        bus.psum_in_ready  = in_ready;
        bus.spad_w_en      = prod_fire && addr_ok;
        bus.spad_w_addr    = '0;
        bus.spad_din       = '0;
        bus.spad_r_addr    = '0;
        bus.psum_out_valid = out_valid_reg;
        bus.psum_out_data  = out_data_reg;
        busy               = (state_reg != IDLE);
        done               = (state_reg == DONE);
        case (state_reg)
            ACCUM: begin
                bus.spad_r_addr = bus.prod_addr;
                bus.spad_w_addr = bus.prod_addr;
                bus.spad_din    = accum_sum;
            end
            DRAIN:   bus.spad_r_addr = ADDR_WIDTH'(drain_cnt_reg);
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            num_psums_reg <= '0;
            drain_cnt_reg <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start && num_ok) begin
                        num_psums_reg <= num_psums;
                        drain_cnt_reg <= '0;
                        state_reg     <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (prod_fire && bus.prod_last) begin
                        drain_cnt_reg <= '0;
                        state_reg     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (in_fire) begin
                        out_data_reg  <= drain_sum;
                        out_valid_reg <= 1'b1;
                        drain_cnt_reg <= drain_cnt_reg + CNT_WIDTH'(1);
                    end else if (bus.psum_out_ready) begin
                        out_valid_reg <= 1'b0;
                        // Pass ends only once the final psum has left the output register.
                        if (!drain_left && out_valid_reg)
                            state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/psum_accum_ctrl.md
Name: psum_accum_ctrl

Overview:
Read-modify-write controller sitting directly upstream of the PE's psum scratchpad. It has three jobs:
- Accept products from the multiplier and accumulate them into psum spad locations.
- Drain the finished psums through the vertical psum chain, adding each incoming psum from the neighbouring PE.
- Emit a done pulse at the end of the pass.
It relies on the spad's posedge write / negedge read timing to complete one accumulation per clock.

Parameters:
- MEM_DEPTH, 24, number of psum spad locations.
- DATA_WIDTH, 16, psum/product width; signed two's complement.
- ADDR_WIDTH, $clog2(MEM_DEPTH), spad address width.
- CNT_WIDTH, $clog2(MEM_DEPTH+1), width of num_psums.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins a pass; sampled only in IDLE.
- num_psums  in  CNT_WIDTH  psums in this pass (1..MEM_DEPTH); latched on start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse at end of pass.
- prod_valid  in  1  product valid.
- prod_ready  out  1  product accepted when valid&&ready.
- prod_data  in  DATA_WIDTH  product.
- prod_addr  in  ADDR_WIDTH  target psum location.
- prod_first  in  1  old value treated as 0 (first MAC into this location).
- prod_last  in  1  final product of the pass.
- psum_in_valid  in  1  psum from PE below.
- psum_in_ready  out  1  handshake for psum_in.
- psum_in_data  in  DATA_WIDTH  incoming psum.
- psum_out_valid  out  1  registered output valid.
- psum_out_ready  in  1  downstream ready.
- psum_out_data  out  DATA_WIDTH  registered output psum.
- spad_w_en  out  1  to spad w_en.
- spad_din  out  DATA_WIDTH  to spad din.
- spad_w_addr  out  ADDR_WIDTH  to spad w_addr.
- spad_r_addr  out  ADDR_WIDTH  to spad r_addr.
- spad_dout  in  DATA_WIDTH  from spad dout; valid after negedge of the cycle r_addr is presented.

Behaviour:
- Reset (async, any state, including mid-pass): state=IDLE, counters=0, psum_out_valid=0, psum_out_data=0, done=0. All combinational outputs evaluate to 0 in IDLE. Spad contents are untouched.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - start && 1<=num_psums<=MEM_DEPTH -> latch num_psums, go to ACCUM.
  - Otherwise, including num_psums out of range, start is ignored.
- start outside IDLE is ignored.
- ACCUM: prod_ready=1, spad_r_addr=prod_addr.
  - On fire: spad_w_en=1, spad_w_addr=prod_addr, spad_din=(prod_first?0:spad_dout)+prod_data. The write is combinational in the fire cycle and commits at the next posedge, so latency is one cycle.
  - Back-to-back fires to the same address need no forwarding: the posedge write precedes the next negedge read.
  - prod_addr>=MEM_DEPTH: product is accepted, write is suppressed.
  - Fire with prod_last -> DRAIN, drain_cnt=0.
- DRAIN: spad_r_addr=drain_cnt; psum_in_ready=(!psum_out_valid||psum_out_ready).
  - On psum_in fire: psum_out_data<=spad_dout+psum_in_data, psum_out_valid<=1, drain_cnt++.
  - psum_out_valid clears on psum_out_ready when no new fire occurs in that cycle.
  - Once drain_cnt reaches num_psums, psum_in_ready=0. After the last output is accepted -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Arithmetic: DATA_WIDTH-bit signed add, wraps modulo 2^DATA_WIDTH (unless PSUM_SAT_EN).
- Outputs stay stable while psum_out_valid && !psum_out_ready.

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined: both adds (accumulate and drain) saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: both adds wrap.

Decomposition:
- Package psum_pkg holds the FSM state encoding (IDLE=0, ACCUM=1, DRAIN=2, DONE=3), the SAT_MAX/SAT_MIN constants, and the saturating-add function.
- One natural sub-module, psum_adder: a combinational DATA_WIDTH adder with wrap/saturate selected by PSUM_SAT_EN. It is instantiated twice, once for accumulate and once for drain.

Test Plan:
- Reset mid-ACCUM after 3 products -> next cycle busy=0, prod_ready=0, spad_w_en=0; a new start with num_psums=2 is accepted.
- num_psums=2; products (addr0,first,5), (addr0,7), (addr1,first,-3,last); drain with psum_in 10, 20 -> psum_out 22, 17; done pulses once.
- Back-to-back 4 products of +1 to addr3, first on the first one -> spad[3]=4, one write per cycle, no stalls.
- Drain with psum_out_ready held low for 5 cycles -> psum_out_data stable, psum_in_ready=0, no counter advance.
- Accumulate 0x7FFF + 1 -> 0x8000 without PSUM_SAT_EN; 0x7FFF with PSUM_SAT_EN; likewise 0x8000 + (-1) -> 0x7FFF vs 0x8000.
- start with num_psums=0 or 25 -> stays IDLE; prod_addr=30 in ACCUM -> accepted, spad_w_en=0.
